// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the NPC core.
// Owns the PC, issues one imem request at a time, hands {instr, inst_pc}
// to decode over valid/ready, and handles execute-stage redirects,
// discarding responses that were already in flight.
// Optional build macro: IFU_ALIGN_CHECK_EN. When it is defined, a misaligned
// redirect target raises a sticky misalign fault.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instr,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 4;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
`ifdef IFU_ALIGN_CHECK_EN
  localparam logic [1:0] S_FAULT = 2'd3;
`endif

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] instr_nxt, inst_pc_nxt;
  logic [XLEN-1:0] redir_tgt;
  logic            drop, drop_nxt;

  // Redirect target: kept as-is for fault reporting, otherwise word-aligned
`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_q, misalign_nxt;
  assign redir_tgt = redirect_pc;
  assign misalign  = misalign_q;
`else
  assign redir_tgt = redirect_pc & ~XLEN'(ILEN - 1);
  assign misalign  = 1'b0;
`endif

  // Outputs decoded from state; the request is suppressed while in reset
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      instr   <= '0;
      inst_pc <= RESET_PC;
`ifdef IFU_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      drop    <= drop_nxt;
      instr   <= instr_nxt;
      inst_pc <= inst_pc_nxt;
`ifdef IFU_ALIGN_CHECK_EN
      misalign_q <= misalign_nxt;
`endif
    end
  end

  // Next-state logic; a redirect always takes priority over pc+4
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    drop_nxt    = drop;
    instr_nxt   = instr;
    inst_pc_nxt = inst_pc;
`ifdef IFU_ALIGN_CHECK_EN
    misalign_nxt = misalign_q;
`endif
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          drop_nxt  = redirect_valid;
        end
        if (redirect_valid) begin
          pc_nxt = redir_tgt;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redir_tgt;
        end
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (drop || redirect_valid) begin
            state_nxt = S_REQ;
          end else begin
            instr_nxt   = imem_rsp_data;
            inst_pc_nxt = pc;
            state_nxt   = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redir_tgt;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + XLEN'(ILEN);
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
`ifdef IFU_ALIGN_CHECK_EN
    if (redirect_valid && (state != S_FAULT) && (redir_tgt[1:0] != 2'b00)) begin
      state_nxt    = S_FAULT;
      misalign_nxt = 1'b1;
      drop_nxt     = 1'b0;
      pc_nxt       = redir_tgt;
    end
`endif
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch with a behavioural instruction memory,
// a scoreboard of expected {inst_pc, instr} deliveries, a vector table of
// plain fetches, and hand-written redirect/reset corner sequences.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instr;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instr          (instr),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          stall;
    logic [31:0] pc;
  } vec_t;

  vec_t        vt[4];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] sb[$];

  // memory model state
  logic        ready_en = 1'b0;
  int          lat      = 1;
  logic        pending  = 1'b0;
  int          pcnt     = 0;
  logic [31:0] paddr    = '0;
  logic        last_acc;
  logic [31:0] last_addr;
  int          last_acc_cyc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive memory, observe request/consume, advance the edge
  task automatic cycle();
    logic        acc;
    logic [31:0] aaddr;
    logic        rspf;
    logic [31:0] e;
    imem_req_ready = ready_en;
    rspf           = pending && (pcnt == lat);
    imem_rsp_valid = rspf;
    imem_rsp_data  = rspf ? memf(paddr) : 32'h0;
    #1;
    acc   = imem_req_valid && imem_req_ready;
    aaddr = imem_req_addr;
    if (inst_valid && inst_ready && !rst) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inst: got pc %h expected no delivery (cycle %0d)", inst_pc, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_instr", instr, memf(e));
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (rspf) pending = 1'b0;
      else if (pending) pcnt++;
      if (acc) begin
        pending = 1'b1;
        pcnt    = 1;
        paddr   = aaddr;
      end
    end
    last_acc  = acc;
    last_addr = aaddr;
    if (acc) last_acc_cyc = cyc;
    cyc++;
  endtask

  task automatic wait_accept(output logic [31:0] addr, output int vseen);
    vseen = 0;
    addr  = '0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) vseen++;
      cycle();
      if (last_acc) begin
        addr = last_addr;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: got no request accepted expected one within 40 cycles");
  endtask

  // After an accept: check latency, stall stability, then consume
  task automatic deliver(input logic [31:0] exp_pc, input int lt, input int stall,
                         input logic redir, input logic [31:0] rpc);
    int n;
    inst_ready = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin
      cycle();
      n++;
    end
    check("rsp_latency", 32'(n), 32'(lt));
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_noreq", 32'(imem_req_valid), 32'd0);
      check("hold_instr", instr, memf(exp_pc));
      check("hold_pc", inst_pc, exp_pc);
      cycle();
    end
    sb.push_back(exp_pc);
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    cycle();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          v;
    int          tprev;
    int          cnt;

    vt[0] = '{lat: 1, stall: 0, pc: 32'h8000_000C};
    vt[1] = '{lat: 2, stall: 5, pc: 32'h8000_0010};
    vt[2] = '{lat: 3, stall: 2, pc: 32'h8000_0014};
    vt[3] = '{lat: 1, stall: 1, pc: 32'h8000_0018};

    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    tprev = 0;
    cycle();
    cycle();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_inst_pc", inst_pc, RST_PC);
    check("rst_addr", imem_req_addr, RST_PC);
    check("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;

    // Zero-wait memory: three fetches, one request every 3 cycles
    ready_en = 1'b1;
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(a, v);
      check("tp_addr", a, RST_PC + 32'(4 * i));
      if (i > 0) check("tp_period", 32'(last_acc_cyc - tprev), 32'd3);
      tprev = last_acc_cyc;
      deliver(RST_PC + 32'(4 * i), 1, 0, 1'b0, 32'h0);
    end

    // Vector table: latency and decode stall variations
    for (int i = 0; i < 4; i++) begin
      lat = vt[i].lat;
      wait_accept(a, v);
      check("vec_addr", a, vt[i].pc);
      deliver(vt[i].pc, vt[i].lat, vt[i].stall, 1'b0, 32'h0);
    end

    // Redirect in S_WAIT, stale response arrives 2 cycles later
    lat = 3;
    inst_ready = 1'b1;
    wait_accept(a, v);
    check("wait_old_addr", a, 32'h8000_001C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    wait_accept(a, v);
    check("wait_redir_addr", a, 32'h8000_0100);
    check("wait_no_valid", 32'(v), 32'd0);
    deliver(32'h8000_0100, 3, 0, 1'b0, 32'h0);

    // Redirect beats inst_ready in S_HOLD
    lat = 1;
    wait_accept(a, v);
    check("hold_old_addr", a, 32'h8000_0104);
    deliver(32'h8000_0104, 1, 0, 1'b1, 32'h8000_0200);
    wait_accept(a, v);
    check("hold_redir_addr", a, 32'h8000_0200);
    deliver(32'h8000_0200, 1, 0, 1'b0, 32'h0);

    // Memory not ready for 4 cycles, then redirect while request is pending
    ready_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, 32'h8000_0204);
      cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0040;
    cycle();
    redirect_valid = 1'b0;
    check("stall_redir_valid", 32'(imem_req_valid), 32'd1);
    check("stall_redir_addr", imem_req_addr, 32'h8000_0040);
    ready_en = 1'b1;
    wait_accept(a, v);
    check("stall_accept_addr", a, 32'h8000_0040);
    deliver(32'h8000_0040, 1, 0, 1'b0, 32'h0);

    // Redirect in the same cycle the request is accepted
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    cycle();
    redirect_valid = 1'b0;
    check("acc_redir_accepted", 32'(last_acc), 32'd1);
    check("acc_redir_old_addr", last_addr, 32'h8000_0044);
    wait_accept(a, v);
    check("acc_redir_new_addr", a, 32'h8000_0300);
    check("acc_redir_no_valid", 32'(v), 32'd0);
    deliver(32'h8000_0300, 1, 0, 1'b0, 32'h0);

    // PC wraps from 0xFFFF_FFFC to 0
    ready_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    ready_en = 1'b1;
    wait_accept(a, v);
    check("wrap_top_addr", a, 32'hFFFF_FFFC);
    deliver(32'hFFFF_FFFC, 1, 0, 1'b0, 32'h0);
    wait_accept(a, v);
    check("wrap_zero_addr", a, 32'h0000_0000);
    deliver(32'h0000_0000, 1, 0, 1'b0, 32'h0);

    // Misaligned redirect target
    ready_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    check("misalign_set", 32'(misalign), 32'd1);
    ready_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req_valid || inst_valid) cnt++;
      cycle();
    end
    check("fault_quiet", 32'(cnt), 32'd0);
    check("misalign_sticky", 32'(misalign), 32'd1);
`else
    cnt = 0;
    check("misalign_zero", 32'(misalign), 32'(cnt));
    ready_en = 1'b1;
    wait_accept(a, v);
    check("align_force_addr", a, 32'h8000_0100);
    deliver(32'h8000_0100, 1, 0, 1'b0, 32'h0);
`endif

    // Reset mid-operation
    rst = 1'b1;
    cycle();
    check("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst2_inst_valid", 32'(inst_valid), 32'd0);
    check("rst2_instr", instr, 32'h0);
    check("rst2_inst_pc", inst_pc, RST_PC);
    check("rst2_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;
    lat = 2;
    wait_accept(a, v);
    check("rst2_addr", a, RST_PC);
    deliver(RST_PC, 2, 0, 1'b0, 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
